// File: rtl/bus_mem_responder.sv
// -----------------------------------------------------------------------------
// bus_mem_responder
//
// Target end of the system bus. It serves 64-byte block reads and writes from
// an internal word array and is used as the behavioural memory behind
// memory_controller, arbiter and cache in unit benches.
//
// Transaction flow:
//   IDLE  : the first request beat carries the byte address, and its tag gives
//           the op (tag MSB: 1 = read, 0 = write). The beat is acked with a
//           one-cycle registered pulse.
//   WDATA : BEATS further request beats each carry one data word. Every beat is
//           acked, and no response is produced.
//   RWAIT : RD_LATENCY idle cycles elapse before the first read beat.
//   RRESP : BEATS response beats are sent. Each beat is held until it is
//           acknowledged with bus_respack.
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous active-high reset (memory is not cleared)
//   bus_reqcyc   in   request beat valid
//   bus_req      in   byte address (first beat) / write data (later beats)
//   bus_reqtag   in   request tag, MSB = op flag
//   bus_reqack   out  one-cycle acknowledge of a request beat
//   bus_respcyc  out  response beat valid
//   bus_resp     out  read data beat
//   bus_resptag  out  tag of the accepted request
//   bus_respack  in   initiator accepts the current response beat
// -----------------------------------------------------------------------------
module bus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int DEPTH_LOG2     = 12,
  parameter int BEATS          = 8,
  parameter int RD_LATENCY     = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  input  logic                      bus_respack
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int BASE_W = DEPTH_LOG2 - BEAT_W;
  localparam int LAT_W  = 4;
  // The lowest address bit of the block index. Byte address bits [2:0]
  // select a byte within a word, and the next BEAT_W bits select a word
  // within the block.
  localparam int BASE_LSB = 3 + BEAT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RWAIT = 2'd2,
    RRESP = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [BEAT_W-1:0]         beat_q, beat_d;
  logic [LAT_W-1:0]          lat_q, lat_d;
  logic                      reqack_q, reqack_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [BASE_W-1:0]         base_q;
  logic                      accept;
  logic                      wr_en;
  logic [DEPTH_LOG2-1:0]     word_idx;

  logic [BUS_DATA_WIDTH-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  // The beat index occupies the low bits of the word index, so a block
  // never crosses its own 8-word boundary.
  assign word_idx = {base_q, beat_q};

  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    reqack_d = 1'b0;
    tag_d    = tag_q;
    accept   = 1'b0;
    wr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        // While reqack is still high (in the cycle right after a write
        // completes), the request beat is stale. Do not accept it.
        if (bus_reqcyc && !reqack_q) begin
          accept   = 1'b1;
          reqack_d = 1'b1;
          tag_d    = bus_reqtag;
          beat_d   = '0;
          if (bus_reqtag[BUS_TAG_WIDTH-1]) begin
            state_d = RWAIT;
            lat_d   = LAT_W'(RD_LATENCY);
          end else begin
            state_d = WDATA;
          end
        end
      end
      WDATA: begin
        // A beat that arrives while reqack is high belongs to the beat
        // being acknowledged. The next data beat is taken one cycle later.
        if (bus_reqcyc && !reqack_q) begin
          wr_en    = 1'b1;
          reqack_d = 1'b1;
          beat_d   = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = IDLE;
          end
        end
      end
      RWAIT: begin
        if (lat_q == '0) begin
          state_d = RRESP;
          beat_d  = '0;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RRESP: begin
        if (bus_respack) begin
          beat_d = beat_q + BEAT_W'(1);
          if (beat_q == BEAT_W'(BEATS - 1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      lat_q    <= '0;
      reqack_q <= 1'b0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      reqack_q <= reqack_d;
      tag_q    <= tag_d;
    end
  end

  // The storage and the latched block base are not reset, so memory
  // contents survive a reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q <= bus_req[DEPTH_LOG2+2:BASE_LSB];
    end
    if (wr_en) begin
      mem[word_idx] <= bus_req;
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = (state_q == RRESP);
  assign bus_resp    = (state_q == RRESP) ? mem[word_idx] : '0;
  assign bus_resptag = tag_q;

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

  localparam int DW    = 64;
  localparam int TW    = 13;
  localparam int BEATS = 8;
  localparam int RDL   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bus_reqcyc;
  logic [DW-1:0] bus_req;
  logic [TW-1:0] bus_reqtag;
  logic          bus_reqack;
  logic          bus_respcyc;
  logic [DW-1:0] bus_resp;
  logic [TW-1:0] bus_resptag;
  logic          bus_respack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] rd_data [BEATS];
  logic [TW-1:0] rd_tag  [BEATS];
  logic          rd_vld  [BEATS];
  logic          rd_after;

  always #5 clk = ~clk;

  bus_mem_responder #(
    .BUS_DATA_WIDTH(DW),
    .BUS_TAG_WIDTH (TW),
    .DEPTH_LOG2    (12),
    .BEATS         (BEATS),
    .RD_LATENCY    (RDL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_reqcyc (bus_reqcyc),
    .bus_req    (bus_req),
    .bus_reqtag (bus_reqtag),
    .bus_reqack (bus_reqack),
    .bus_respcyc(bus_respcyc),
    .bus_resp   (bus_resp),
    .bus_resptag(bus_resptag),
    .bus_respack(bus_respack)
  );

  // Present one request beat and hold it until it is acknowledged.
  // The task returns #1 after the edge that makes reqack visible.
  task automatic send_beat(input logic [DW-1:0] d, input logic [TW-1:0] t);
    int cyc;
    bus_reqcyc = 1'b1;
    bus_req    = d;
    bus_reqtag = t;
    cyc        = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!bus_reqack && cyc < 40);
    n_checks++;
    if (bus_reqack !== 1'b1) begin
      n_fail++;
      $display("FAIL reqack_timeout: reqack=%b after %0d cycles, required 1", bus_reqack, cyc);
    end
  endtask

  task automatic write_block(input logic [DW-1:0] addr, input logic [DW-1:0] d0);
    send_beat(addr, 13'h0000);
    for (int i = 0; i < BEATS; i++) send_beat(d0 + DW'(i), 13'h0000);
    bus_reqcyc = 1'b0;
  endtask

  task automatic read_request(input logic [DW-1:0] addr, input logic [TW-1:0] t);
    send_beat(addr, t);
    bus_reqcyc = 1'b0;
  endtask

  // Count the cycles from the current point until respcyc is high.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!bus_respcyc && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    n_checks++;
    if (bus_respcyc !== 1'b1) begin
      n_fail++;
      $display("FAIL respcyc_timeout: respcyc=%b after %0d cycles, required 1", bus_respcyc, lat);
      lat = -1;
    end
  endtask

  // Receive a full block with respack held high.
  task automatic collect_read(output int lat);
    wait_resp(lat);
    bus_respack = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      rd_data[i] = bus_resp;
      rd_tag[i]  = bus_resptag;
      rd_vld[i]  = bus_respcyc;
      @(posedge clk); #1;
    end
    bus_respack = 1'b0;
    rd_after = bus_respcyc;
  endtask

  task automatic test_reset;
    reset       = 1'b1;
    bus_reqcyc  = 1'b0;
    bus_req     = '0;
    bus_reqtag  = '0;
    bus_respack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({bus_reqack, bus_respcyc} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctl: reqack/respcyc=%b required 00", {bus_reqack, bus_respcyc});
    end
    n_checks++;
    if (bus_resp !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_resp: got %h required 0", bus_resp);
    end
    n_checks++;
    if (bus_resptag !== 13'h0) begin
      n_fail++;
      $display("FAIL reset_resptag: got %h required 0", bus_resptag);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({bus_reqack, bus_respcyc} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_no_ack cycle %0d: reqack/respcyc=%b required 00", i, {bus_reqack, bus_respcyc});
      end
    end
  endtask

  task automatic test_write_read;
    int lat;
    write_block(64'h1040, 64'h1111_0000);
    @(posedge clk); #1;
    n_checks++;
    if (bus_respcyc !== 1'b0) begin
      n_fail++;
      $display("FAIL write_no_resp: respcyc=%b required 0", bus_respcyc);
    end
    read_request(64'h1040, 13'h1005);
    collect_read(lat);
    n_checks++;
    if (lat != RDL + 1) begin
      n_fail++;
      $display("FAIL rd_latency: got %0d cycles required %0d", lat, RDL + 1);
    end
    for (int i = 0; i < BEATS; i++) begin
      n_checks++;
      if (rd_vld[i] !== 1'b1 || rd_data[i] !== 64'h1111_0000 + 64'(i) || rd_tag[i] !== 13'h1005) begin
        n_fail++;
        $display("FAIL wr_rd_beat%0d: vld=%b data=%h tag=%h required 1 %h 1005",
                 i, rd_vld[i], rd_data[i], rd_tag[i], 64'h1111_0000 + 64'(i));
      end
    end
    n_checks++;
    if (rd_after !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_end_drop: respcyc=%b required 0", rd_after);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    write_block(64'h2000, 64'hAAAA_0000);
    read_request(64'h2000, 13'h1022);
    wait_resp(lat);
    bus_respack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus_resp !== 64'hAAAA_0000 + 64'(i)) begin
        n_fail++;
        $display("FAIL bp_beat%0d: got %h required %h", i, bus_resp, 64'hAAAA_0000 + 64'(i));
      end
      @(posedge clk); #1;
    end
    bus_respack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus_respcyc !== 1'b1 || bus_resp !== 64'hAAAA_0003) begin
        n_fail++;
        $display("FAIL bp_hold%0d: respcyc=%b data=%h required 1 aaaa0003", k, bus_respcyc, bus_resp);
      end
    end
    bus_respack = 1'b1;
    @(posedge clk); #1;
    for (int i = 4; i < BEATS; i++) begin
      n_checks++;
      if (bus_respcyc !== 1'b1 || bus_resp !== 64'hAAAA_0000 + 64'(i)) begin
        n_fail++;
        $display("FAIL bp_stream%0d: respcyc=%b data=%h required 1 %h",
                 i, bus_respcyc, bus_resp, 64'hAAAA_0000 + 64'(i));
      end
      @(posedge clk); #1;
    end
    bus_respack = 1'b0;
    n_checks++;
    if (bus_respcyc !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_end: respcyc=%b required 0", bus_respcyc);
    end
  endtask

  task automatic test_addr_wrap;
    int lat;
    write_block(64'h8040, 64'h5555_0000);
    read_request(64'h0040, 13'h1040);
    collect_read(lat);
    for (int i = 0; i < BEATS; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'h5555_0000 + 64'(i)) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got %h required %h", i, rd_data[i], 64'h5555_0000 + 64'(i));
      end
    end
    read_request(64'h0078, 13'h1078);
    collect_read(lat);
    for (int i = 0; i < BEATS; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'h5555_0000 + 64'(i) || rd_tag[i] !== 13'h1078) begin
        n_fail++;
        $display("FAIL offset_beat%0d: data=%h tag=%h required %h 1078",
                 i, rd_data[i], rd_tag[i], 64'h5555_0000 + 64'(i));
      end
    end
  endtask

  task automatic test_busy;
    int lat;
    write_block(64'h3000, 64'hCCCC_0000);
    read_request(64'h1040, 13'h1001);
    wait_resp(lat);
    bus_reqcyc  = 1'b1;
    bus_req     = 64'h3000;
    bus_reqtag  = 13'h1ABC;
    bus_respack = 1'b1;
    for (int i = 0; i < BEATS; i++) begin
      n_checks++;
      if (bus_reqack !== 1'b0 || bus_resp !== 64'h1111_0000 + 64'(i) || bus_resptag !== 13'h1001) begin
        n_fail++;
        $display("FAIL busy_beat%0d: reqack=%b data=%h tag=%h required 0 %h 1001",
                 i, bus_reqack, bus_resp, bus_resptag, 64'h1111_0000 + 64'(i));
      end
      @(posedge clk); #1;
    end
    bus_respack = 1'b0;
    n_checks++;
    if ({bus_respcyc, bus_reqack} !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_idle: respcyc/reqack=%b required 00", {bus_respcyc, bus_reqack});
    end
    @(posedge clk); #1;
    n_checks++;
    if (bus_reqack !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_accept: reqack=%b required 1", bus_reqack);
    end
    bus_reqcyc = 1'b0;
    collect_read(lat);
    n_checks++;
    if (lat != RDL + 1) begin
      n_fail++;
      $display("FAIL busy_latency: got %0d required %0d", lat, RDL + 1);
    end
    for (int i = 0; i < BEATS; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'hCCCC_0000 + 64'(i) || rd_tag[i] !== 13'h1ABC) begin
        n_fail++;
        $display("FAIL second_rd_beat%0d: data=%h tag=%h required %h 1abc",
                 i, rd_data[i], rd_tag[i], 64'hCCCC_0000 + 64'(i));
      end
    end
  endtask

  task automatic test_reset_mid_read;
    int lat;
    read_request(64'h1040, 13'h1007);
    wait_resp(lat);
    bus_respack = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_respack = 1'b0;
    n_checks++;
    if (bus_resp !== 64'h1111_0002) begin
      n_fail++;
      $display("FAIL mid_beat2: got %h required 11110002", bus_resp);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus_respcyc, bus_reqack} !== 2'b00 || bus_resp !== 64'h0 || bus_resptag !== 13'h0) begin
      n_fail++;
      $display("FAIL async_reset: respcyc=%b reqack=%b data=%h tag=%h required 0 0 0 0",
               bus_respcyc, bus_reqack, bus_resp, bus_resptag);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    read_request(64'h1040, 13'h1008);
    collect_read(lat);
    for (int i = 0; i < BEATS; i++) begin
      n_checks++;
      if (rd_data[i] !== 64'h1111_0000 + 64'(i) || rd_tag[i] !== 13'h1008) begin
        n_fail++;
        $display("FAIL reread_beat%0d: data=%h tag=%h required %h 1008",
                 i, rd_data[i], rd_tag[i], 64'h1111_0000 + 64'(i));
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_write_read;
    test_backpressure;
    test_addr_wrap;
    test_busy;
    test_reset_mid_read;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
